// File: rtl/motor_pkg.sv
// Shared encodings for the motor command ramp: command codes, directions, channel states
// and small helpers used by the top level.
package motor_pkg;

  localparam logic [2:0] CMD_STOP  = 3'd0;
  localparam logic [2:0] CMD_FWD   = 3'd1;
  localparam logic [2:0] CMD_REV   = 3'd2;
  localparam logic [2:0] CMD_LEFT  = 3'd3;
  localparam logic [2:0] CMD_RIGHT = 3'd4;

  localparam logic [6:0] DUTY_MAX = 7'd100;

  localparam logic DIR_F = 1'b0;
  localparam logic DIR_R = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StRamp,
    StRampDn,
    StDead,
    StHold
  } ch_state_e;

  function automatic logic [6:0] clamp_duty(input logic [6:0] s);
    return (s > DUTY_MAX) ? DUTY_MAX : s;
  endfunction

  // {reverse input, forward input} for one motor.
  function automatic logic [13:0] motor_fields(input logic d, input logic [6:0] l);
    return (d == DIR_F) ? {7'd0, l} : {l, 7'd0};
  endfunction

  function automatic logic is_settled(input ch_state_e s);
    return (s == StIdle) || (s == StHold);
  endfunction

endpackage

// File: rtl/motor_channel_ramp.sv
// One motor's duty ramp: steps its level toward the registered target on each tick and
// inserts a zero-level dead interval before the direction flips.
module motor_channel_ramp
  import motor_pkg::*;
#(
  parameter int unsigned RAMP_STEP = 5,
  parameter int unsigned DEAD_CYC  = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic       clr,
  input  logic       tgt_dir,
  input  logic [6:0] tgt_level,
  output logic [6:0] level,
  output logic       dir,
  output ch_state_e  state
);

  localparam int unsigned DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [7:0] STEP = 8'(RAMP_STEP);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYC - 1);

  logic          dir_tgt_q;
  logic [6:0]    lvl_tgt_q;
  logic [DW-1:0] dead_cnt_q;
  logic [7:0]    lvl_w, tgt_w, up_w, dn_w, nxt_w, dz_w;

  // 8-bit intermediates so level + step cannot wrap before it is compared to the target.
  assign lvl_w = {1'b0, level};
  assign tgt_w = {1'b0, lvl_tgt_q};
  assign up_w  = (lvl_w + STEP >= tgt_w) ? tgt_w : lvl_w + STEP;
  assign dn_w  = (lvl_w >= tgt_w + STEP) ? lvl_w - STEP : tgt_w;
  assign nxt_w = (lvl_w < tgt_w) ? up_w : dn_w;
  assign dz_w  = (lvl_w > STEP) ? lvl_w - STEP : 8'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      level      <= '0;
      dir        <= DIR_F;
      dir_tgt_q  <= DIR_F;
      lvl_tgt_q  <= '0;
      dead_cnt_q <= '0;
    end else if (clr) begin
      state      <= StIdle;
      level      <= '0;
      dir_tgt_q  <= dir;
      lvl_tgt_q  <= '0;
      dead_cnt_q <= '0;
    end else if (load && (state != StDead)) begin
      dir_tgt_q <= tgt_dir;
      lvl_tgt_q <= tgt_level;
      if ((tgt_dir != dir) && (level != '0)) begin
        state <= StRampDn;
      end else begin
        // Level is already 0 or direction unchanged, so switching now is safe.
        dir <= tgt_dir;
        if (tgt_level != level) state <= StRamp;
        else                    state <= (level == '0) ? StIdle : StHold;
      end
    end else begin
      unique case (state)
        StRamp: begin
          if (tick) begin
            level <= nxt_w[6:0];
            if (nxt_w == tgt_w) state <= (lvl_tgt_q == '0) ? StIdle : StHold;
          end
        end
        StRampDn: begin
          if (tick) begin
            level <= dz_w[6:0];
            if (dz_w == 8'd0) begin
              state      <= StDead;
              dead_cnt_q <= '0;
            end
          end
        end
        StDead: begin
          if (dead_cnt_q == DEAD_LAST) begin
            dir   <= dir_tgt_q;
            state <= (lvl_tgt_q == '0) ? StIdle : StRamp;
          end else begin
            dead_cnt_q <= dead_cnt_q + 1'b1;
          end
        end
        StIdle, StHold: ;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/motor_cmd_ramp.sv
// Motion command to packed L298N duty bus with per-motor ramping and a dead interval on
// reversal. Define MOTOR_ESTOP_EN to add the synchronous emergency-stop input estop.
module motor_cmd_ramp
  import motor_pkg::*;
#(
  parameter int unsigned RAMP_DIV  = 50000,
  parameter int unsigned RAMP_STEP = 5,
  parameter int unsigned DEAD_CYC  = 100000
) (
  input  logic        clk,
  input  logic        rst,
`ifdef MOTOR_ESTOP_EN
  input  logic        estop,
`endif
  input  logic [2:0]  cmd,
  input  logic [6:0]  speed,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [27:0] duty,
  output logic        busy
);

  localparam int unsigned PW = $clog2(RAMP_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(RAMP_DIV - 1);

  logic [PW-1:0] pre_q;
  logic          tick;
  logic          estop_w;
  logic          load;
  logic [6:0]    spd;
  logic [6:0]    lvl_t;
  logic          l_dir_t, r_dir_t;
  logic [6:0]    l_level, r_level;
  logic          l_dir, r_dir;
  ch_state_e     l_state, r_state;

`ifdef MOTOR_ESTOP_EN
  assign estop_w = estop;
`else
  assign estop_w = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  pre_q <= '0;
    else if (pre_q == PRE_LAST) pre_q <= '0;
    else                      pre_q <= pre_q + 1'b1;
  end

  assign tick = (pre_q == PRE_LAST);

  assign spd = clamp_duty(speed);

  // STOP keeps each motor's present direction so it ramps down without a dead interval.
  always_comb begin
    l_dir_t = l_dir;
    r_dir_t = r_dir;
    lvl_t   = spd;
    case (cmd)
      CMD_FWD:   begin l_dir_t = DIR_F; r_dir_t = DIR_F; end
      CMD_REV:   begin l_dir_t = DIR_R; r_dir_t = DIR_R; end
      CMD_LEFT:  begin l_dir_t = DIR_R; r_dir_t = DIR_F; end
      CMD_RIGHT: begin l_dir_t = DIR_F; r_dir_t = DIR_R; end
      default:   lvl_t = '0;
    endcase
  end

  assign cmd_ready = !estop_w && (l_state != StDead) && (r_state != StDead);
  assign load      = cmd_valid && cmd_ready;

  motor_channel_ramp #(
    .RAMP_STEP(RAMP_STEP),
    .DEAD_CYC (DEAD_CYC)
  ) u_left (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (load),
    .clr      (estop_w),
    .tgt_dir  (l_dir_t),
    .tgt_level(lvl_t),
    .level    (l_level),
    .dir      (l_dir),
    .state    (l_state)
  );

  motor_channel_ramp #(
    .RAMP_STEP(RAMP_STEP),
    .DEAD_CYC (DEAD_CYC)
  ) u_right (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (load),
    .clr      (estop_w),
    .tgt_dir  (r_dir_t),
    .tgt_level(lvl_t),
    .level    (r_level),
    .dir      (r_dir),
    .state    (r_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty <= '0;
      busy <= 1'b0;
    end else if (estop_w) begin
      duty <= '0;
      busy <= 1'b0;
    end else begin
      duty <= {motor_fields(r_dir, r_level), motor_fields(l_dir, l_level)};
      busy <= !(is_settled(l_state) && is_settled(r_state));
    end
  end

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// Bench for motor_cmd_ramp: command table plus hand-written retarget, reset and estop cases,
// with a scoreboard of expected duty words checked whenever the duty bus changes.
`timescale 1ns/1ps
module tb_motor_cmd_ramp;
  import motor_pkg::*;

  localparam int unsigned RAMP_DIV  = 4;
  localparam int unsigned RAMP_STEP = 10;
  localparam int unsigned DEAD_CYC  = 8;
  localparam int TB_STEP = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cmd = 3'd0;
  logic [6:0]  speed = 7'd0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [27:0] duty;
  logic        busy;
`ifdef MOTOR_ESTOP_EN
  logic        estop = 1'b0;
`endif

  motor_cmd_ramp #(
    .RAMP_DIV (RAMP_DIV),
    .RAMP_STEP(RAMP_STEP),
    .DEAD_CYC (DEAD_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef MOTOR_ESTOP_EN
    .estop    (estop),
`endif
    .cmd      (cmd),
    .speed    (speed),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .duty     (duty),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [27:0] duty;
    int          gap;
  } sb_t;

  typedef struct {
    logic [2:0]  cmd;
    logic [6:0]  speed;
    logic [27:0] final_duty;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[8];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, last_chg = 0, low_cnt = 0, last_low = 0;
  bit saw_low = 0, saw_busy = 0, mon_en = 0;
  logic [27:0] prev_duty = '0;

  // Bench-side motor model: direction bit 1 means reverse.
  logic m_dl = 1'b0, m_dr = 1'b0;
  int   m_lvl = 0;
  bit   m_dead = 0;

  function automatic logic [27:0] mk(input int a, input int b, input int c, input int d);
    return {7'(d), 7'(c), 7'(b), 7'(a)};
  endfunction

  function automatic logic [27:0] pk(input logic dl, input logic dr, input int l);
    return mk(dl ? 0 : l, dl ? l : 0, dr ? 0 : l, dr ? l : 0);
  endfunction

  function automatic bit fields_ok(input logic [27:0] d);
    logic [6:0] f0, f1, f2, f3;
    f0 = d[6:0]; f1 = d[13:7]; f2 = d[20:14]; f3 = d[27:21];
    if (f0 > 7'd100 || f1 > 7'd100 || f2 > 7'd100 || f3 > 7'd100) return 0;
    if ((f0 != 0 && f1 != 0) || (f2 != 0 && f3 != 0)) return 0;
    return 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(negedge clk);
    cyc++;
    check("field invariant", {31'd0, fields_ok(duty)}, 32'd1);
    if (busy === 1'b1) saw_busy = 1;
    if (cmd_ready !== 1'b1) begin
      low_cnt++;
      saw_low = 1;
    end else if (low_cnt != 0) begin
      last_low = low_cnt;
      low_cnt  = 0;
    end
    if (duty !== prev_duty) begin
      if (mon_en) begin
        if (sb_q.size() == 0) begin
          check("unexpected duty change", {4'd0, duty}, {4'd0, prev_duty});
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check("duty step", {4'd0, duty}, {4'd0, e.duty});
          if (e.gap != 0) check("step spacing", cyc - last_chg, e.gap);
        end
      end
      prev_duty = duty;
      last_chg  = cyc;
    end
  end

  task automatic push(input logic [27:0] d, input int gap);
    sb_t e;
    e.duty = d;
    e.gap  = gap;
    sb_q.push_back(e);
  endtask

  // Expected duty words for both motors moving in lock-step to a common level.
  task automatic push_cmd(input logic [2:0] c, input logic [6:0] s);
    logic tdl, tdr;
    int t, lvl;
    bit first;
    t = (s > 7'd100) ? 100 : int'(s);
    tdl = m_dl; tdr = m_dr;
    case (c)
      3'd1: begin tdl = 1'b0; tdr = 1'b0; end
      3'd2: begin tdl = 1'b1; tdr = 1'b1; end
      3'd3: begin tdl = 1'b1; tdr = 1'b0; end
      3'd4: begin tdl = 1'b0; tdr = 1'b1; end
      default: t = 0;
    endcase
    lvl = m_lvl;
    first = 1;
    m_dead = 0;
    if ((tdl != m_dl || tdr != m_dr) && lvl > 0) begin
      while (lvl > 0) begin
        lvl = (lvl > TB_STEP) ? lvl - TB_STEP : 0;
        push(pk(m_dl, m_dr, lvl), first ? 0 : 4);
        first = 0;
      end
      m_dead = 1;
      first  = 1;
    end
    m_dl = tdl; m_dr = tdr;
    while (lvl != t) begin
      if (lvl < t) lvl = (lvl + TB_STEP > t) ? t : lvl + TB_STEP;
      else         lvl = (lvl - TB_STEP < t) ? t : lvl - TB_STEP;
      push(pk(m_dl, m_dr, lvl), first ? 0 : 4);
      first = 0;
    end
    m_lvl = t;
  endtask

  task automatic send(input logic [2:0] c, input logic [6:0] s);
    @(negedge clk);
    #1;
    check("cmd_ready before send", {31'd0, cmd_ready}, 32'd1);
    cmd = c; speed = s; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input bit idle);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while ((sb_q.size() != 0 || (idle && busy !== 1'b0)) && n < 600);
    if (n >= 600) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain timeout: %0d entries left, busy %b", sb_q.size(), busy);
      sb_q.delete();
    end
  endtask

  initial begin
    vecs[0] = '{3'd1, 7'd35,  mk(35, 0, 35, 0)};
    vecs[1] = '{3'd1, 7'd50,  mk(50, 0, 50, 0)};
    vecs[2] = '{3'd2, 7'd50,  mk(0, 50, 0, 50)};
    vecs[3] = '{3'd1, 7'd127, mk(100, 0, 100, 0)};
    vecs[4] = '{3'd6, 7'd90,  mk(0, 0, 0, 0)};
    vecs[5] = '{3'd3, 7'd20,  mk(0, 20, 20, 0)};
    vecs[6] = '{3'd4, 7'd20,  mk(20, 0, 0, 20)};
    vecs[7] = '{3'd0, 7'd0,   mk(0, 0, 0, 0)};

    repeat (3) @(negedge clk);
    check("reset duty", {4'd0, duty}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
    rst = 1'b0;
    mon_en = 1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      saw_low = 0; last_low = 0; saw_busy = 0;
      push_cmd(vecs[i].cmd, vecs[i].speed);
      send(vecs[i].cmd, vecs[i].speed);
      wait_drain(1);
      check($sformatf("vec%0d final duty", i), {4'd0, duty}, {4'd0, vecs[i].final_duty});
      check($sformatf("vec%0d cmd_ready", i), {31'd0, cmd_ready}, 32'd1);
      check($sformatf("vec%0d busy seen", i), {31'd0, saw_busy}, 32'd1);
      if (m_dead) check($sformatf("vec%0d dead cycles", i), last_low, DEAD_CYC);
      else        check($sformatf("vec%0d no dead", i), {31'd0, saw_low}, 32'd0);
    end

    // Retarget during ramp-down back to the original direction: no dead interval.
    push_cmd(3'd1, 7'd40);
    send(3'd1, 7'd40);
    wait_drain(1);
    saw_low = 0;
    push(mk(30, 0, 30, 0), 0);
    send(3'd2, 7'd40);
    wait_drain(0);
    push(mk(40, 0, 40, 0), 0);
    send(3'd1, 7'd40);
    wait_drain(1);
    check("retarget no dead", {31'd0, saw_low}, 32'd0);
    check("retarget final", {4'd0, duty}, {4'd0, mk(40, 0, 40, 0)});

    // Asynchronous reset mid-ramp at level 30.
    push(mk(30, 0, 30, 0), 0);
    send(3'd0, 7'd0);
    wait_drain(0);
    mon_en = 0;
    rst = 1'b1;
    #1;
    check("async reset duty", {4'd0, duty}, 32'd0);
    check("async reset busy", {31'd0, busy}, 32'd0);
    check("async reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_dl = 1'b0; m_dr = 1'b0; m_lvl = 0;
    repeat (3) @(negedge clk);
    #2;
    check("post reset duty", {4'd0, duty}, 32'd0);
    check("post reset busy", {31'd0, busy}, 32'd0);
    check("post reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
    mon_en = 1;

`ifdef MOTOR_ESTOP_EN
    push_cmd(3'd1, 7'd80);
    send(3'd1, 7'd80);
    wait_drain(1);
    @(negedge clk);
    mon_en = 0;
    estop = 1'b1;
    check("duty before estop edge", {4'd0, duty}, {4'd0, mk(80, 0, 80, 0)});
    @(posedge clk);
    #1;
    check("estop duty", {4'd0, duty}, 32'd0);
    check("estop cmd_ready", {31'd0, cmd_ready}, 32'd0);
    repeat (3) @(negedge clk);
    check("estop held cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("estop held duty", {4'd0, duty}, 32'd0);
    estop = 1'b0;
    m_lvl = 0;
    @(negedge clk);
    #2;
    mon_en = 1;
    saw_low = 0;
    push_cmd(3'd1, 7'd20);
    send(3'd1, 7'd20);
    wait_drain(1);
    check("post estop no dead", {31'd0, saw_low}, 32'd0);
    check("post estop final", {4'd0, duty}, {4'd0, mk(20, 0, 20, 0)});
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
